// File: rtl/systolic_deskew_collector_if.sv
// Bus between the systolic array output skew and the aligned-vector consumer.
// Valid semantics: validIn marks lane 0 of a new vector; a vector is consumed only when validOut & enable.
interface systolic_deskew_collector_if #(
  parameter int numOfOutputs = 4,
  parameter int bitwidth     = 8,
  parameter int countWidth   = 8
);
  logic                             enable;
  logic                             validIn;
  logic [numOfOutputs*bitwidth-1:0] dataIn;
  logic [numOfOutputs*bitwidth-1:0] dataOut;
  logic                             validOut;
  logic                             lastOut;
  logic [countWidth-1:0]            vectorIndex;

  modport master (
    output enable, validIn, dataIn,
    input  dataOut, validOut, lastOut, vectorIndex
  );

  modport slave (
    input  enable, validIn, dataIn,
    output dataOut, validOut, lastOut, vectorIndex
  );
endinterface

// File: rtl/systolic_deskew_collector.sv
// Deskews time-skewed systolic lanes into aligned vectors and frames them
// into blocks with a per-block index and an end-of-block marker.
module systolic_deskew_collector #(
  parameter int numOfOutputs    = 4,
  parameter int bitwidth        = 8,
  parameter int vectorsPerBlock = 16,
  parameter int countWidth      = 8
) (
  input logic                   clock,
  input logic                   reset,
  systolic_deskew_collector_if.slave bus
);
  localparam int N = numOfOutputs;
  localparam int W = bitwidth;
  localparam logic [countWidth-1:0] LAST_IDX = countWidth'(vectorsPerBlock - 1);

  logic [N*W-1:0]        data_out;
  logic [N-1:0]          vld;
  logic [N-1:0]          vld_next;
  logic [countWidth-1:0] cnt;
  logic [countWidth-1:0] idx;
  logic                  last;

  // Lane i arrives i cycles late, so it gets N-i registers to line up with lane 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = N - i;
    logic [W-1:0] stage [D];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int j = 0; j < D; j++) stage[j] <= '0;
      end else if (bus.enable) begin
        stage[0] <= bus.dataIn[i*W +: W];
        for (int j = 1; j < D; j++) stage[j] <= stage[j-1];
      end
    end

    assign data_out[i*W +: W] = stage[D-1];
  end

  if (N == 1) begin : g_vld_one
    assign vld_next = bus.validIn;
  end else begin : g_vld_many
    assign vld_next = {vld[N-2:0], bus.validIn};
  end

  // Index and last are captured on the same edge that loads the final valid stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld  <= '0;
      cnt  <= '0;
      idx  <= '0;
      last <= 1'b0;
    end else if (bus.enable) begin
      vld <= vld_next;
      if (vld_next[N-1]) begin
        idx  <= cnt;
        last <= (cnt == LAST_IDX);
        cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end else begin
        last <= 1'b0;
      end
    end
  end

  assign bus.dataOut     = data_out;
  assign bus.validOut    = vld[N-1];
  assign bus.lastOut     = last;
  assign bus.vectorIndex = idx;
endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Directed bench for the deskew collector: N=4, 8-bit lanes, 3 vectors per block.
module tb_systolic_deskew_collector;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int VPB = 3;
  localparam int CW  = 8;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  int          launch [8];
  logic [31:0] vec    [8];
  int          nvec;
  logic [31:0] exp_q [$];

  systolic_deskew_collector_if #(.numOfOutputs(N), .bitwidth(W), .countWidth(CW)) bus ();

  systolic_deskew_collector #(
    .numOfOutputs(N), .bitwidth(W), .vectorsPerBlock(VPB), .countWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.enable  = 1'b0;
    bus.validIn = 1'b0;
    bus.dataIn  = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Skewed input word for enabled cycle e: lane i carries vector k when launch[k]+i == e.
  function automatic logic [31:0] compose(int e, bit ff);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < N; i++) begin
      b = ff ? 8'hFF : 8'((e * 37 + i * 11) ^ 90);
      for (int k = 0; k < nvec; k++)
        if (launch[k] + i == e) b = vec[k][i*8 +: 8];
      w[i*8 +: 8] = b;
    end
    return w;
  endfunction

  function automatic bit is_launch(int e);
    for (int k = 0; k < nvec; k++)
      if (launch[k] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    bus.enable  = 1'b1;
    bus.validIn = 1'b1;
    bus.dataIn  = 32'hDEADBEEF;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", bus.dataOut); end
    checks++;
    if (bus.validOut !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.validOut); end
    checks++;
    if (bus.lastOut !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bus.lastOut); end
    checks++;
    if (bus.vectorIndex !== 8'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", bus.vectorIndex); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    nvec = 1; launch[0] = 0; vec[0] = 32'h44332211;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (bus.validOut !== (c == 4)) begin
        errors++; $display("FAIL single_valid c=%0d got %b exp %b", c, bus.validOut, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (bus.dataOut !== 32'h44332211) begin errors++; $display("FAIL single_data got %h exp 44332211", bus.dataOut); end
        checks++;
        if (bus.vectorIndex !== 8'd0) begin errors++; $display("FAIL single_index got %0d exp 0", bus.vectorIndex); end
        checks++;
        if (bus.lastOut !== 1'b0) begin errors++; $display("FAIL single_last got %b exp 0", bus.lastOut); end
      end
      bus.enable  = 1'b1;
      bus.validIn = is_launch(c);
      bus.dataIn  = compose(c, 1'b1);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int k;
    do_reset();
    nvec = 7;
    for (int v = 0; v < 7; v++) begin
      launch[v] = v;
      vec[v] = {8'(16*v + 3), 8'(16*v + 2), 8'(16*v + 1), 8'(16*v)};
    end
    exp_q.delete();
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if (bus.validOut !== (c >= 4 && c <= 10)) begin
        errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, bus.validOut, (c >= 4 && c <= 10));
      end
      if (c >= 4 && c <= 10) begin
        k = c - 4;
        w = exp_q.pop_front();
        checks++;
        if (bus.dataOut !== w) begin errors++; $display("FAIL stream_data k=%0d got %h exp %h", k, bus.dataOut, w); end
        checks++;
        if (bus.vectorIndex !== 8'(k % 3)) begin errors++; $display("FAIL stream_index k=%0d got %0d exp %0d", k, bus.vectorIndex, k % 3); end
        checks++;
        if (bus.lastOut !== (k % 3 == 2)) begin errors++; $display("FAIL stream_last k=%0d got %b exp %b", k, bus.lastOut, (k % 3 == 2)); end
      end
      if (c < 7) exp_q.push_back(vec[c]);
      bus.enable  = 1'b1;
      bus.validIn = is_launch(c);
      bus.dataIn  = compose(c, 1'b1);
      tick();
    end
  endtask

  task automatic test_stall();
    int  e;
    bit  en;
    do_reset();
    nvec = 1; launch[0] = 0; vec[0] = 32'h44332211;
    e = 0;
    for (int c = 0; c <= 8; c++) begin
      checks++;
      if (bus.validOut !== (c == 7)) begin
        errors++; $display("FAIL stall_valid c=%0d got %b exp %b", c, bus.validOut, (c == 7));
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (bus.dataOut !== 32'hFFFF0000) begin errors++; $display("FAIL stall_hold c=%0d got %h exp ffff0000", c, bus.dataOut); end
      end
      if (c == 7) begin
        checks++;
        if (bus.dataOut !== 32'h44332211) begin errors++; $display("FAIL stall_data got %h exp 44332211", bus.dataOut); end
        checks++;
        if (bus.vectorIndex !== 8'd0) begin errors++; $display("FAIL stall_index got %0d exp 0", bus.vectorIndex); end
      end
      en = !(c >= 2 && c <= 4);
      bus.enable  = en;
      bus.validIn = en && is_launch(e);
      bus.dataIn  = compose(e, 1'b1);
      tick();
      if (en) e++;
    end
  endtask

  // Runs straight after the stream test, so the block counter enters non-zero.
  task automatic test_mid_reset();
    nvec = 2;
    launch[0] = 0; vec[0] = 32'h53525150;
    launch[1] = 1; vec[1] = 32'h63626160;
    for (int c = 0; c <= 14; c++) begin
      if (c == 2) begin
        reset = 1'b1;
        #1;
        checks++;
        if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 00000000", bus.dataOut); end
        checks++;
        if (bus.vectorIndex !== 8'd0) begin errors++; $display("FAIL midrst_index got %0d exp 0", bus.vectorIndex); end
        checks++;
        if (bus.lastOut !== 1'b0) begin errors++; $display("FAIL midrst_last got %b exp 0", bus.lastOut); end
      end
      if (c == 4) reset = 1'b0;
      if (c == 10) begin
        nvec = 1; launch[0] = 10; vec[0] = 32'hA3A2A1A0;
      end
      if (c >= 2) begin
        checks++;
        if (bus.validOut !== (c == 14)) begin
          errors++; $display("FAIL midrst_valid c=%0d got %b exp %b", c, bus.validOut, (c == 14));
        end
      end
      if (c == 14) begin
        checks++;
        if (bus.dataOut !== 32'hA3A2A1A0) begin errors++; $display("FAIL midrst_after_data got %h exp a3a2a1a0", bus.dataOut); end
        checks++;
        if (bus.vectorIndex !== 8'd0) begin errors++; $display("FAIL midrst_after_index got %0d exp 0", bus.vectorIndex); end
      end
      bus.enable  = 1'b1;
      bus.validIn = (c < 2 || c >= 10) && is_launch(c);
      bus.dataIn  = compose(c, 1'b0);
      tick();
    end
  endtask

  task automatic test_sparse();
    logic [31:0] w;
    int k;
    bit ev;
    do_reset();
    nvec = 4;
    for (int v = 0; v < 4; v++) begin
      launch[v] = 5 * v;
      vec[v] = {8'(8'hC0 + v), 8'(8'h80 + v), 8'(8'h40 + v), 8'(v + 1)};
    end
    exp_q.delete();
    for (int c = 0; c <= 20; c++) begin
      ev = (c >= 4) && ((c - 4) % 5 == 0) && (c <= 19);
      checks++;
      if (bus.validOut !== ev) begin errors++; $display("FAIL sparse_valid c=%0d got %b exp %b", c, bus.validOut, ev); end
      if (ev) begin
        k = (c - 4) / 5;
        w = exp_q.pop_front();
        checks++;
        if (bus.dataOut !== w) begin errors++; $display("FAIL sparse_data k=%0d got %h exp %h", k, bus.dataOut, w); end
        checks++;
        if (bus.vectorIndex !== 8'(k % 3)) begin errors++; $display("FAIL sparse_index k=%0d got %0d exp %0d", k, bus.vectorIndex, k % 3); end
        checks++;
        if (bus.lastOut !== (k % 3 == 2)) begin errors++; $display("FAIL sparse_last k=%0d got %b exp %b", k, bus.lastOut, (k % 3 == 2)); end
      end
      if (is_launch(c)) exp_q.push_back(vec[c / 5]);
      bus.enable  = 1'b1;
      bus.validIn = is_launch(c);
      bus.dataIn  = compose(c, 1'b0);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    reset  = 1'b1;
    bus.enable  = 1'b0;
    bus.validIn = 1'b0;
    bus.dataIn  = '0;
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_reset();
    test_stall();
    test_sparse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
